multicycle_ctrl: RTL

- Multicycle control FSM for the RV32I subset CPU: add, sub, and, or, addi, andi, ori, lw, sw, beq, jal.
- Drives the ALU control interface (ALUOp, ALUSrc, funct7, funct3) and consumes its zero flag.
- Sequences instruction fetch, execute, memory access and writeback around a shared memory with a ready handshake.
- Sits between the instruction register, ALU, register file, PC and memory port.

---
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and the RV32I datapath.
// The controller takes the master modport; the datapath or a bench takes the slave side.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  ALUOp;
  logic        ALUSrc;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic        mem_read;
  logic        mem_write;
  logic        i_or_d;
  logic        ir_write;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        pc_write;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic        halted;
  logic [1:0]  error;

  modport master (
    input  instr, zero, mem_ready,
    output ALUOp, ALUSrc, funct7, funct3, mem_read, mem_write, i_or_d, ir_write,
           reg_write, wb_sel, pc_write, pc_sel, state, halted, error
  );

  modport slave (
    output instr, zero, mem_ready,
    input  ALUOp, ALUSrc, funct7, funct3, mem_read, mem_write, i_or_d, ir_write,
           reg_write, wb_sel, pc_write, pc_sel, state, halted, error
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for an RV32I subset core (add/sub/and/or/addi/andi/ori/lw/sw/beq/jal).
// Sequences fetch, decode, execute, memory and writeback around a shared ready-handshake memory.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [2:0] K_RTYPE = 3'd0;
  localparam logic [2:0] K_ADDI  = 3'd1;
  localparam logic [2:0] K_LOGI  = 3'd2;
  localparam logic [2:0] K_LW    = 3'd3;
  localparam logic [2:0] K_SW    = 3'd4;
  localparam logic [2:0] K_BEQ   = 3'd5;
  localparam logic [2:0] K_JAL   = 3'd6;
  localparam logic [2:0] K_BAD   = 3'd7;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

  logic [2:0]       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic [1:0]       r_error, w_error_next;
  logic [2:0]       r_kind, w_kind;
  logic [1:0]       r_aluop, w_aluop;
  logic             r_alusrc, w_alusrc;
  logic [6:0]       r_f7, w_f7;
  logic [2:0]       r_f3, w_f3;
  logic [6:0]       w_opcode, w_funct7;
  logic [2:0]       w_funct3;
  logic             w_timeout;

  assign w_opcode  = bus.instr[6:0];
  assign w_funct3  = bus.instr[14:12];
  assign w_funct7  = bus.instr[31:25];
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (w_cnt_inc == TIMEOUT);

  always_comb begin
    w_kind = K_BAD;
    case (w_opcode)
      7'b0110011: begin
        if ((w_funct7 == 7'b0000000 &&
             (w_funct3 == 3'b000 || w_funct3 == 3'b110 || w_funct3 == 3'b111)) ||
            (w_funct7 == 7'b0100000 && w_funct3 == 3'b000))
          w_kind = K_RTYPE;
      end
      7'b0010011: begin
        if (w_funct3 == 3'b000)
          w_kind = K_ADDI;
        else if (w_funct3 == 3'b110 || w_funct3 == 3'b111)
          w_kind = K_LOGI;
      end
      7'b0000011: w_kind = K_LW;
      7'b0100011: w_kind = K_SW;
      7'b1100011: w_kind = K_BEQ;
      7'b1101111: w_kind = K_JAL;
      default:    w_kind = K_BAD;
    endcase
  end

  // ALU control is captured at DECODE so it stays stable through EXEC, MEM and WB.
  always_comb begin
    w_aluop  = 2'b00;
    w_alusrc = 1'b0;
    w_f7     = 7'b0;
    w_f3     = 3'b0;
    case (w_kind)
      K_RTYPE: begin
        w_aluop = 2'b10;
        w_f7    = w_funct7;
        w_f3    = w_funct3;
      end
      K_ADDI, K_LW, K_SW: w_alusrc = 1'b1;
      K_LOGI: begin
        w_aluop  = 2'b10;
        w_alusrc = 1'b1;
        w_f3     = w_funct3;
      end
      K_BEQ:   w_aluop = 2'b01;
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_error_next = r_error;
    case (r_state)
      S_FETCH, S_MEM: begin
        if (bus.mem_ready) begin
          w_cnt_next = '0;
          if (r_state == S_FETCH)
            w_state_next = S_DECODE;
          else
            w_state_next = (r_kind == K_LW) ? S_WB : S_FETCH;
        end else begin
          w_cnt_next = w_cnt_inc;
          if (w_timeout) begin
            w_state_next = S_HALT;
            w_error_next = 2'b10;
          end
        end
      end
      S_DECODE: begin
        w_cnt_next = '0;
        if (w_kind == K_BAD) begin
          w_state_next = S_HALT;
          w_error_next = 2'b01;
        end else begin
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (r_kind)
          K_BEQ:       w_state_next = S_FETCH;
          K_LW, K_SW:  w_state_next = S_MEM;
          default:     w_state_next = S_WB;
        endcase
      end
      S_WB:    w_state_next = S_FETCH;
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_cnt    <= '0;
      r_error  <= 2'b00;
      r_kind   <= K_RTYPE;
      r_aluop  <= 2'b00;
      r_alusrc <= 1'b0;
      r_f7     <= 7'b0;
      r_f3     <= 3'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_error <= w_error_next;
      if (r_state == S_DECODE) begin
        r_kind   <= w_kind;
        r_aluop  <= w_aluop;
        r_alusrc <= w_alusrc;
        r_f7     <= w_f7;
        r_f3     <= w_f3;
      end
    end
  end

  // While rst is high the outputs already show the FETCH values so an aborted op writes nothing.
  always_comb begin
    bus.ALUOp     = 2'b00;
    bus.ALUSrc    = 1'b0;
    bus.funct7    = 7'b0;
    bus.funct3    = 3'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.i_or_d    = 1'b0;
    bus.ir_write  = 1'b0;
    bus.reg_write = 1'b0;
    bus.wb_sel    = 2'b00;
    bus.pc_write  = 1'b0;
    bus.pc_sel    = 2'b00;
    bus.state     = r_state;
    bus.halted    = 1'b0;
    bus.error     = 2'b00;
    if (rst) begin
      bus.mem_read = 1'b1;
    end else begin
      if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
        bus.ALUOp  = r_aluop;
        bus.ALUSrc = r_alusrc;
        bus.funct7 = r_f7;
        bus.funct3 = r_f3;
      end
      bus.error = r_error;
      case (r_state)
        S_FETCH: begin
          bus.mem_read = 1'b1;
          bus.ir_write = bus.mem_ready;
        end
        S_EXEC: begin
          if (r_kind == K_BEQ) begin
            bus.pc_write = 1'b1;
            bus.pc_sel   = bus.zero ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          bus.i_or_d    = 1'b1;
          bus.mem_read  = (r_kind == K_LW);
          bus.mem_write = (r_kind == K_SW);
          bus.pc_write  = (r_kind == K_SW) && bus.mem_ready;
        end
        S_WB: begin
          bus.reg_write = 1'b1;
          bus.pc_write  = 1'b1;
          bus.wb_sel    = (r_kind == K_LW) ? 2'b01 : ((r_kind == K_JAL) ? 2'b10 : 2'b00);
          bus.pc_sel    = (r_kind == K_JAL) ? 2'b10 : 2'b00;
        end
        S_HALT:  bus.halted = 1'b1;
        default: ;
      endcase
    end
  end
endmodule
